// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input, command port and error strobes of the UART command parser.
// LW must equal $clog2(MAX_PAYLOAD+1) of the connected parser.
interface uart_cmd_parser_if #(
   parameter int LW = 5
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_frame_error;
   logic          cmd_ready;
   logic [LW-1:0] payload_rd_addr;
   logic          cmd_valid;
   logic [7:0]    cmd_id;
   logic [LW-1:0] cmd_len;
   logic [7:0]    payload_rd_data;
   logic          busy;
   logic          err_frame;
   logic          err_length;
   logic          err_checksum;
   logic          err_timeout;
   logic          err_overrun;

   modport master (
      output rx_data, rx_valid, rx_frame_error, cmd_ready, payload_rd_addr,
      input  cmd_valid, cmd_id, cmd_len, payload_rd_data, busy,
      input  err_frame, err_length, err_checksum, err_timeout, err_overrun
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_error, cmd_ready, payload_rd_addr,
      output cmd_valid, cmd_id, cmd_len, payload_rd_data, busy,
      output err_frame, err_length, err_checksum, err_timeout, err_overrun
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream into sync/cmd/len/payload/xor-checksum packets
// and holds each checked command until the consumer handshakes it.
//
// state   | meaning
// HUNT    | waiting for SYNC_BYTE
// CMD     | expecting command id
// LEN     | expecting payload length
// PAYLOAD | collecting payload bytes
// CHECK   | expecting checksum byte
// PENDING | command presented, waiting for cmd_ready
module uart_cmd_parser #(
   parameter int         MAX_PAYLOAD    = 16,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input logic          clk,
   input logic          reset,
   uart_cmd_parser_if.slave bus
);
   localparam int LW = $clog2(MAX_PAYLOAD + 1);
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [2:0] HUNT    = 3'd0;
   localparam logic [2:0] CMD     = 3'd1;
   localparam logic [2:0] LEN     = 3'd2;
   localparam logic [2:0] PAYLOAD = 3'd3;
   localparam logic [2:0] CHECK   = 3'd4;
   localparam logic [2:0] PENDING = 3'd5;

   logic [2:0]    state;
   logic [7:0]    csum;
   logic [LW-1:0] idx;
   logic [TW-1:0] tmr;
   logic          cmd_valid;
   logic [7:0]    cmd_id;
   logic [LW-1:0] cmd_len;
   logic          err_frame, err_length, err_checksum, err_timeout, err_overrun;
   logic [7:0]    pay_mem [2**AW];

   wire [7:0] d = bus.rx_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= HUNT;
         csum         <= '0;
         idx          <= '0;
         tmr          <= '0;
         cmd_valid    <= 1'b0;
         cmd_id       <= '0;
         cmd_len      <= '0;
         err_frame    <= 1'b0;
         err_length   <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         err_frame    <= 1'b0;
         err_length   <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
         case (state)
            HUNT: begin
               tmr <= '0;
               if (bus.rx_valid && !bus.rx_frame_error && d == SYNC_BYTE)
                  state <= CMD;
            end
            PENDING: begin
               if (bus.rx_valid)
                  err_overrun <= 1'b1;
               if (bus.cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= HUNT;
               end
            end
            default: begin
               if (bus.rx_frame_error) begin
                  err_frame <= 1'b1;
                  state     <= HUNT;
               end else if (bus.rx_valid) begin
                  tmr <= '0;
                  case (state)
                     CMD: begin
                        cmd_id <= d;
                        csum   <= d;
                        state  <= LEN;
                     end
                     LEN: begin
                        if ({24'd0, d} > 32'(MAX_PAYLOAD)) begin
                           err_length <= 1'b1;
                           state      <= HUNT;
                        end else begin
                           cmd_len <= LW'(d);
                           csum    <= csum ^ d;
                           idx     <= '0;
                           state   <= (d == 8'd0) ? CHECK : PAYLOAD;
                        end
                     end
                     PAYLOAD: begin
                        csum <= csum ^ d;
                        idx  <= idx + LW'(1);
                        if (idx + LW'(1) == cmd_len)
                           state <= CHECK;
                     end
                     CHECK: begin
                        if (d == csum) begin
                           cmd_valid <= 1'b1;
                           state     <= PENDING;
                        end else begin
                           err_checksum <= 1'b1;
                           state        <= HUNT;
                        end
                     end
                     default: state <= HUNT;
                  endcase
               end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  tmr         <= '0;
                  state       <= HUNT;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
         endcase
      end
   end

   // Payload storage carries no reset; contents matter only while a command is pending.
   always_ff @(posedge clk) begin
      if (!reset && state == PAYLOAD && bus.rx_valid && !bus.rx_frame_error)
         pay_mem[idx[AW-1:0]] <= d;
   end

   assign bus.payload_rd_data = (bus.payload_rd_addr < LW'(MAX_PAYLOAD)) ?
                                pay_mem[bus.payload_rd_addr[AW-1:0]] : 8'h00;
   assign bus.busy         = |state;
   assign bus.cmd_valid    = cmd_valid;
   assign bus.cmd_id       = cmd_id;
   assign bus.cmd_len      = cmd_len;
   assign bus.err_frame    = err_frame;
   assign bus.err_length   = err_length;
   assign bus.err_checksum = err_checksum;
   assign bus.err_timeout  = err_timeout;
   assign bus.err_overrun  = err_overrun;
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Packet-level controller that sits directly behind the UART byte receiver and sequences its output stream into framed commands. It hunts for a sync byte, then collects command ID, length, payload and XOR checksum. Complete packets are presented on a valid/ready command port with random-access payload reads. Framing errors, length violations, checksum mismatches, inter-byte timeouts and overruns are reported as one-cycle error pulses.

## Interface
- `MAX_PAYLOAD`, default 16: maximum payload bytes; sets the buffer depth. Must be ≥1.
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `TIMEOUT_CYCLES`, default 100000: idle clk cycles allowed between bytes inside a packet. Must be ≥2.
- Derived `LW = $clog2(MAX_PAYLOAD+1)`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte, qualified by `rx_valid`.
- `rx_valid` in 1: one-cycle pulse, byte with good stop bit.
- `rx_frame_error` in 1: high for ≥1 cycle on a bad stop bit.
- `cmd_ready` in 1: consumer accepts the pending command.
- `payload_rd_addr` in LW: payload read index.
- `cmd_valid` out 1: complete, checked command pending.
- `cmd_id` out 8: command byte.
- `cmd_len` out LW: payload length, 0..MAX_PAYLOAD.
- `payload_rd_data` out 8: combinational read of `buf[payload_rd_addr]`; reads 0 when addr ≥ MAX_PAYLOAD.
- `busy` out 1: high in every state except HUNT.
- `err_frame`, `err_length`, `err_checksum`, `err_timeout`, `err_overrun` out 1 each: one-cycle error pulses.

## Operation
- States: HUNT, CMD, LEN, PAYLOAD, CHECK, PENDING. A byte event means `rx_valid` is high.
- HUNT: a byte equal to SYNC_BYTE moves to CMD. Other bytes are dropped silently.
- CMD: store `cmd_id`, set csum=byte, then go to LEN.
- LEN:
  - If byte > MAX_PAYLOAD: pulse `err_length`, go to HUNT.
  - Otherwise store `cmd_len`, csum ^= byte, idx=0.
  - Go to CHECK if byte==0, else PAYLOAD.
- PAYLOAD: buf[idx]=byte, csum ^= byte, idx++. The byte taken with idx==cmd_len-1 moves to CHECK.
- CHECK:
  - If byte==csum: go to PENDING with `cmd_valid`=1.
  - Otherwise pulse `err_checksum`, go to HUNT.
- PENDING:
  - Hold `cmd_valid`, `cmd_id`, `cmd_len` and the buffer stable.
  - `cmd_valid && cmd_ready` returns to HUNT on the next edge.
  - Any byte event in PENDING, including the handshake cycle, is dropped and pulses `err_overrun`.
- Frame error: `rx_frame_error` high in CMD, LEN, PAYLOAD or CHECK pulses `err_frame` and goes to HUNT. It is ignored in HUNT and PENDING, so a multi-cycle level yields exactly one pulse.
- Timeout (CMD through CHECK only):
  - Counter clears on the sync byte and on every accepted byte, and increments on each cycle without a byte event.
  - When a cycle with no byte event finds counter == TIMEOUT_CYCLES-1, pulse `err_timeout` and go to HUNT.
- Priority within one cycle: `rx_frame_error` > `rx_valid` > timeout. A byte arriving together with a frame error is discarded.
- Buffer is not reset. `payload_rd_data` is defined only while `cmd_valid`=1 and addr < `cmd_len`.
- Checksum is an 8-bit XOR of CMD, LEN and all payload bytes.

## Timing
- Reset: state HUNT; `cmd_valid`, `cmd_id`, `cmd_len`, `busy` and all err_* are 0; counters are 0.
- `reset` during any state aborts the packet without an error pulse and drops any pending command.
- All outputs except `payload_rd_data` are registered.
- `cmd_valid` rises on the edge after the cycle carrying the checksum byte.
- Error pulses assert on the edge after the triggering cycle, last exactly one cycle, and never overlap each other.
- `cmd_valid` falls on the edge after the `cmd_ready` handshake cycle.
- A new sync byte is accepted from the first cycle in HUNT.
- `payload_rd_data` changes in the same cycle as `payload_rd_addr`.

## Test plan
- Good packet: bytes 33, A5, 10, 02, 3C, 5A, 74 with `cmd_ready`=0.
  - Response: `cmd_valid`=1 one cycle after 74; `cmd_id`=10, `cmd_len`=2, reads of addr0/addr1 give 3C/5A.
  - Values hold for 20 cycles. Raising `cmd_ready` clears `cmd_valid` on the next edge, and `busy` drops.
- Zero length: A5, 20, 00, 20 → `cmd_valid` with `cmd_len`=0 and `cmd_id`=20.
- Bad checksum and recovery: A5, 10, 02, 3C, 5A, 75 → one `err_checksum` pulse and no `cmd_valid`. A following good packet is accepted normally.
- Length violation (MAX_PAYLOAD=16): A5, 10, 11 → `err_length` pulse and HUNT. A subsequent 11 is ignored.
- Timeout (TIMEOUT_CYCLES=8): A5, 10, then no bytes → `err_timeout` on the edge ending idle cycle 8, and `busy`=0.
  - A byte arriving on idle cycle 7 prevents the timeout.
- Overrun and frame error:
  - A byte during PENDING gives `err_overrun` with `cmd_id`, `cmd_len` and payload unchanged.
  - `rx_frame_error` held 2 cycles mid-PAYLOAD gives exactly one `err_frame` pulse, then HUNT.
  - `reset` mid-PAYLOAD gives all outputs 0 and no error pulse.
